// File: rtl/t01_pkg.sv
// t01_pkg: shared piece width, empty-piece code and queue FSM states.
package t01_pkg;
  localparam int PIECE_W = 3;
  localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd7;
  typedef enum logic [1:0] {S_INIT, S_FILL, S_FULL} state_e;
endpackage

// File: rtl/t01_shift_fifo.sv
// t01_shift_fifo: DEPTH x 3-bit FIFO whose entries shift toward the head (entry 0) on pop.
module t01_shift_fifo import t01_pkg::*; #(
  parameter int DEPTH = 3,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [PIECE_W-1:0]         din_i,
  output logic [CW-1:0]              count_o,
  output logic [DEPTH*PIECE_W-1:0]   ent_o
);
  localparam int EW = DEPTH * PIECE_W;
  logic [CW-1:0] cnt_q, cnt_d, wr;
  logic [EW-1:0] ent_q, ent_d, shf;
  logic pop, push;
  always_comb begin
    pop   = pop_i && cnt_q != '0;
    push  = push_i && (cnt_q != CW'(DEPTH) || pop);
    shf   = pop ? ent_q >> PIECE_W : ent_q;
    wr    = cnt_q - CW'(pop);
    ent_d = push ? (shf & ~(EW'({PIECE_W{1'b1}}) << (wr * PIECE_W))) | (EW'(din_i) << (wr * PIECE_W)) : shf;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ent_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end
  assign count_o = cnt_q;
  assign ent_o   = ent_q;
endmodule

// File: rtl/t01_piece_queue.sv
// t01_piece_queue: preview queue pulling pieces from the generator, re-rolling immediate repeats.
module t01_piece_queue import t01_pkg::*; #(
  parameter int DEPTH      = 3,
  parameter int MAX_REROLL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic [PIECE_W-1:0] block_type_in,
  output logic               lfsr_enable,
  input  logic               spawn_req,
  output logic [PIECE_W-1:0] piece_out,
  output logic               piece_valid,
  output logic [PIECE_W-1:0] next_piece,
  output logic               queue_full,
  output logic               spawn_miss
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(MAX_REROLL + 2);
  state_e state_q, state_d;
  logic [CW-1:0] count;
  logic [DEPTH*PIECE_W-1:0] ent;
  logic [PIECE_W-1:0] last_q, last_d;
  logic [RW-1:0] reroll_q, reroll_d;
  logic miss_q, pop, draw, rep, push;
  t01_shift_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (block_type_in),
    .count_o (count),
    .ent_o   (ent)
  );
  // Repeat check is against the last enqueued piece; 7 is a no-piece code and never consumes a reroll.
  always_comb begin
    pop      = spawn_req && piece_valid;
    draw     = (state_q == S_FILL || (state_q == S_FULL && pop)) && !pause;
    rep      = draw && block_type_in != PIECE_NONE && block_type_in == last_q && reroll_q < RW'(MAX_REROLL);
    push     = draw && block_type_in != PIECE_NONE && !rep;
    last_d   = push ? block_type_in : last_q;
    reroll_d = push ? '0 : rep ? reroll_q + 1'b1 : reroll_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_INIT;
      last_q   <= PIECE_NONE;
      reroll_q <= '0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      reroll_q <= reroll_d;
      miss_q   <= spawn_req && !piece_valid;
    end
  end
  always_comb begin
    state_d = state_q == S_INIT ? S_FILL : (count + CW'(push) - CW'(pop)) == CW'(DEPTH) ? S_FULL : S_FILL;
  end
  always_comb begin
    lfsr_enable = draw;
    piece_valid = count != '0;
    piece_out   = piece_valid ? ent[PIECE_W-1:0] : '0;
    next_piece  = count >= CW'(2) ? ent[2*PIECE_W-1:PIECE_W] : '0;
    queue_full  = count == CW'(DEPTH);
    spawn_miss  = miss_q;
  end
endmodule

// File: tb/tb_t01_piece_queue.sv
// tb_t01_piece_queue: table-driven directed checks of the piece queue against a stub generator.
module tb_t01_piece_queue;
  logic clk, rst, pause, spawn_req, lfsr_enable, piece_valid, queue_full, spawn_miss;
  logic [2:0] block_type_in, piece_out, next_piece;
  logic [2:0] seqs [3][16];
  logic [23:0] src [3];
  logic [3:0] gi;
  int sel, errors, checks;
  typedef struct {
    logic       spawn;
    logic       pause;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[$];
  int s1a, s1b, s5a, s5b, s3a, s3b, s4a, s4b;
  t01_piece_queue #(.DEPTH(3), .MAX_REROLL(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .pause         (pause),
    .block_type_in (block_type_in),
    .lfsr_enable   (lfsr_enable),
    .spawn_req     (spawn_req),
    .piece_out     (piece_out),
    .piece_valid   (piece_valid),
    .next_piece    (next_piece),
    .queue_full    (queue_full),
    .spawn_miss    (spawn_miss)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Stub generator: advances one entry on each edge where the queue draws.
  always @(posedge clk or posedge rst) begin
    if (rst) gi <= '0;
    else if (lfsr_enable) gi <= gi + 4'd1;
  end
  assign block_type_in = seqs[sel][gi];
  function automatic logic [9:0] outs();
    return {piece_out, next_piece, piece_valid, queue_full, lfsr_enable, spawn_miss};
  endfunction
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got po=%0d np=%0d v=%b f=%b en=%b miss=%b, expected po=%0d np=%0d v=%b f=%b en=%b miss=%b",
               name, act[9:7], act[6:4], act[3], act[2], act[1], act[0],
               exp[9:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask
  task automatic add(input logic s, input logic p, input logic [2:0] po, input logic [2:0] np,
                     input logic v, input logic f, input logic e, input logic m);
    tbl.push_back('{s, p, {po, np, v, f, e, m}});
  endtask
  task automatic run(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      spawn_req = tbl[i].spawn;
      pause     = tbl[i].pause;
      #1;
      chk($sformatf("%s[%0d]", tag, i - lo), outs(), tbl[i].exp);
      @(negedge clk);
    end
    spawn_req = 1'b0;
    pause     = 1'b0;
  endtask
  task automatic reset_to(input int k);
    rst = 1'b1;
    sel = k;
    spawn_req = 1'b0;
    pause = 1'b0;
    #1;
    chk("in_reset", outs(), 10'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; pause = 1'b0; spawn_req = 1'b0; sel = 0; errors = 0; checks = 0;
    src[0] = {3'd2, 3'd6, 3'd5, 3'd3, 3'd1, 3'd0, 3'd0, 3'd4};
    src[1] = {3'd7, 3'd7, 3'd7, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2};
    src[2] = {3'd7, 3'd6, 3'd5, 3'd5, 3'd7, 3'd5, 3'd7, 3'd7};
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        seqs[k][i] = i < 8 ? src[k][3*i +: 3] : 3'd7;
    // Release, fill 4,0,(0 rerolled),1; pop with draw; paused pops; drain to empty.
    s1a = tbl.size();
    add(0,0, 0,0,0,0,0,0);
    add(0,0, 0,0,0,0,1,0);
    add(0,0, 4,0,1,0,1,0);
    add(0,0, 4,0,1,0,1,0);
    add(0,0, 4,0,1,0,1,0);
    add(0,0, 4,0,1,1,0,0);
    add(1,0, 4,0,1,1,1,0);
    add(0,0, 0,1,1,1,0,0);
    add(1,1, 0,1,1,1,0,0);
    add(0,1, 1,3,1,0,0,0);
    add(0,1, 1,3,1,0,0,0);
    add(0,0, 1,3,1,0,1,0);
    add(0,0, 1,3,1,1,0,0);
    add(1,0, 1,3,1,1,1,0);
    add(0,0, 3,5,1,1,0,0);
    add(1,1, 3,5,1,1,0,0);
    add(1,1, 5,6,1,0,0,0);
    add(1,1, 6,0,1,0,0,0);
    add(1,1, 0,0,0,0,0,0);
    add(0,1, 0,0,0,0,0,1);
    add(0,1, 0,0,0,0,0,0);
    s1b = tbl.size() - 1;
    // spawn_req during S_INIT, then pause while filling.
    s5a = tbl.size();
    add(1,0, 0,0,0,0,0,0);
    add(0,1, 0,0,0,0,0,1);
    add(0,1, 0,0,0,0,0,0);
    add(0,0, 0,0,0,0,1,0);
    add(0,0, 4,0,1,0,1,0);
    s5b = tbl.size() - 1;
    // Generator 2,2,2,3,4: one rejection then the repeat is accepted.
    s3a = tbl.size();
    add(0,0, 0,0,0,0,0,0);
    add(0,0, 0,0,0,0,1,0);
    add(0,0, 2,0,1,0,1,0);
    add(0,0, 2,0,1,0,1,0);
    add(0,0, 2,2,1,0,1,0);
    add(0,0, 2,2,1,1,0,0);
    add(1,0, 2,2,1,1,1,0);
    add(0,0, 2,3,1,1,0,0);
    s3b = tbl.size() - 1;
    // Generator 7,7,5,7,5,5,6: sevens discarded without consuming a reroll.
    s4a = tbl.size();
    add(0,0, 0,0,0,0,0,0);
    add(0,0, 0,0,0,0,1,0);
    add(0,0, 0,0,0,0,1,0);
    add(0,0, 0,0,0,0,1,0);
    add(0,0, 5,0,1,0,1,0);
    add(0,0, 5,0,1,0,1,0);
    add(0,0, 5,0,1,0,1,0);
    add(0,0, 5,5,1,0,1,0);
    add(0,0, 5,5,1,1,0,0);
    s4b = tbl.size() - 1;
    @(negedge clk);
    reset_to(0);
    run("s1", s1a, s1b);
    reset_to(0);
    run("s5", s5a, s5b);
    reset_to(1);
    run("s3", s3a, s3b);
    reset_to(2);
    run("s4", s4a, s4b);
    reset_to(0);
    run("s6pre", s1a, s1a + 3);
    rst = 1'b1;
    #1;
    chk("s6_mid_reset", outs(), 10'd0);
    @(negedge clk);
    rst = 1'b0;
    run("s6", s1a, s1b);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
